// File: rtl/rx_batch_decimator.sv
// Per-channel batch decimator: combines 2^k input batches into one output batch
// using average, signed peak or saturating sum, with a one-deep output register per channel.
module rx_batch_decimator #(
  parameter int CHANNELS         = 8,
  parameter int PARALLEL_SAMPLES = 8,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int MAX_LOG2_N       = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]                              data_in_valid,
  input  logic [$clog2(MAX_LOG2_N+1)-1:0]                  cfg_log2_n,
  input  logic [1:0]                                       cfg_mode,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]                              data_out_valid,
  input  logic [CHANNELS-1:0]                              data_out_ready,
  output logic [CHANNELS-1:0]                              overflow
);

  localparam int KW    = $clog2(MAX_LOG2_N + 1);
  localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2_N;
  localparam int BW    = CHANNELS * PARALLEL_SAMPLES * SAMPLE_WIDTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_PEAK = 2'd1,
    MODE_SUM  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  logic [KW-1:0]           pend_k;
  mode_t                   pend_mode;
  logic [KW-1:0]           act_k    [CHANNELS];
  mode_t                   act_mode [CHANNELS];
  logic [MAX_LOG2_N-1:0]   count_q  [CHANNELS];
  logic signed [ACC_W-1:0] acc_q    [CHANNELS][PARALLEL_SAMPLES];
  logic [BW-1:0]           data_out_q;
  logic [CHANNELS-1:0]     out_valid_q;
  logic [CHANNELS-1:0]     overflow_q;

  logic                    blk_end  [CHANNELS];
  logic signed [ACC_W-1:0] acc_next [CHANNELS][PARALLEL_SAMPLES];
  logic [SAMPLE_WIDTH-1:0] result   [CHANNELS][PARALLEL_SAMPLES];

  logic          cfg_accept;
  logic [KW-1:0] cfg_k_clamped;

  assign cfg_ready      = !reset;
  assign cfg_accept     = cfg_valid && cfg_ready;
  assign cfg_k_clamped  = (cfg_log2_n > KW'(MAX_LOG2_N)) ? KW'(MAX_LOG2_N) : cfg_log2_n;
  assign data_out       = data_out_q;
  assign data_out_valid = out_valid_q;
  assign overflow       = overflow_q;

  // A channel at a block boundary uses the pending config directly, so the first
  // batch of a block and every later batch agree on k and mode.
  always_comb begin
    logic                    first;
    logic [KW-1:0]           eff_k;
    mode_t                   eff_mode;
    logic [MAX_LOG2_N-1:0]   limit;
    logic signed [ACC_W-1:0] sx;
    logic signed [ACC_W-1:0] shifted;
    first    = 1'b0;
    eff_k    = '0;
    eff_mode = MODE_AVG;
    limit    = '0;
    sx       = '0;
    shifted  = '0;
    blk_end  = '{default: 1'b0};
    acc_next = '{default: '0};
    result   = '{default: '0};
    for (int c = 0; c < CHANNELS; c++) begin
      first      = (count_q[c] == '0);
      eff_k      = first ? pend_k : act_k[c];
      eff_mode   = first ? pend_mode : act_mode[c];
      limit      = ~({MAX_LOG2_N{1'b1}} << eff_k);
      blk_end[c] = (count_q[c] == limit);
      for (int j = 0; j < PARALLEL_SAMPLES; j++) begin
        sx = {{MAX_LOG2_N{data_in[(c*PARALLEL_SAMPLES+j)*SAMPLE_WIDTH + SAMPLE_WIDTH-1]}},
              data_in[(c*PARALLEL_SAMPLES+j)*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
        if (first)
          acc_next[c][j] = sx;
        else if (eff_mode == MODE_PEAK)
          acc_next[c][j] = (sx > acc_q[c][j]) ? sx : acc_q[c][j];
        else
          acc_next[c][j] = acc_q[c][j] + sx;
        shifted = acc_next[c][j] >>> eff_k;
        case (eff_mode)
          MODE_PEAK: result[c][j] = acc_next[c][j][SAMPLE_WIDTH-1:0];
          MODE_SUM: begin
            if (acc_next[c][j] > SAT_MAX)
              result[c][j] = SAT_MAX[SAMPLE_WIDTH-1:0];
            else if (acc_next[c][j] < SAT_MIN)
              result[c][j] = SAT_MIN[SAMPLE_WIDTH-1:0];
            else
              result[c][j] = acc_next[c][j][SAMPLE_WIDTH-1:0];
          end
          default: result[c][j] = shifted[SAMPLE_WIDTH-1:0];
        endcase
      end
    end
  end

  // A drop on a full output register sets overflow even in the cycle a config clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_k      <= '0;
      pend_mode   <= MODE_AVG;
      data_out_q  <= '0;
      out_valid_q <= '0;
      overflow_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        act_k[c]    <= '0;
        act_mode[c] <= MODE_AVG;
        count_q[c]  <= '0;
        for (int j = 0; j < PARALLEL_SAMPLES; j++) acc_q[c][j] <= '0;
      end
    end else begin
      if (cfg_accept) begin
        pend_k     <= cfg_k_clamped;
        pend_mode  <= mode_t'(cfg_mode);
        overflow_q <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (count_q[c] == '0) begin
          act_k[c]    <= pend_k;
          act_mode[c] <= pend_mode;
        end
        if (data_in_valid[c]) begin
          count_q[c] <= blk_end[c] ? '0 : count_q[c] + MAX_LOG2_N'(1);
          for (int j = 0; j < PARALLEL_SAMPLES; j++) acc_q[c][j] <= acc_next[c][j];
        end
        if (data_in_valid[c] && blk_end[c]) begin
          if (!out_valid_q[c] || data_out_ready[c]) begin
            out_valid_q[c] <= 1'b1;
            for (int j = 0; j < PARALLEL_SAMPLES; j++)
              data_out_q[(c*PARALLEL_SAMPLES+j)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= result[c][j];
          end else begin
            overflow_q[c] <= 1'b1;
          end
        end else if (out_valid_q[c] && data_out_ready[c]) begin
          out_valid_q[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rx_batch_decimator.md
# rx_batch_decimator

Multi-channel receive-chain decimator that combines N = 2^k consecutive parallel-sample batches from each ADC channel into a single output batch. N is runtime-programmable. The combine mode is average, peak (signed max) or saturating sum. The block sits between the RFDC-facing sample stream (CHANNELS × PARALLEL_SAMPLES × SAMPLE_WIDTH at PL_CLK_MHZ) and the downstream capture/trigger logic. It lowers the data rate and adds output backpressure with per-channel overflow reporting.

## Interface
Parameters:
- CHANNELS, default 8: independent ADC channels.
- PARALLEL_SAMPLES, default 8: samples per batch (RFDC_CLK_MHZ/PL_CLK_MHZ).
- SAMPLE_WIDTH, default 16: signed two's-complement sample width.
- MAX_LOG2_N, default 8: largest supported k; the accumulator is SAMPLE_WIDTH+MAX_LOG2_N bits signed.

Ports:
- clk  in  1  sole clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- data_in  in  CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH  channel c, sample j at bits [(c*PARALLEL_SAMPLES+j)*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- data_in_valid  in  CHANNELS  per-channel input strobe; there is no input backpressure.
- cfg_log2_n  in  $clog2(MAX_LOG2_N+1)  requested k.
- cfg_mode  in  2  0 = average, 1 = peak, 2 = saturating sum, 3 = reserved (behaves as average).
- cfg_valid  in  1  configuration strobe.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- data_out  out  same layout as data_in  decimated batch.
- data_out_valid  out  CHANNELS  per-channel output valid.
- data_out_ready  in  CHANNELS  per-channel downstream ready.
- overflow  out  CHANNELS  sticky flag: a result was dropped.

## Operation
- Configuration:
  - cfg_ready = !reset.
  - An accepted transaction writes a shared pending register. If cfg_log2_n > MAX_LOG2_N it is clamped to MAX_LOG2_N.
  - A later transaction overwrites an unapplied pending value; the latest value wins.
  - Acceptance clears all overflow bits.
- Active config (k, mode) is held per channel.
  - The channel loads the pending config only at a block boundary: count == 0 with no partial accumulation.
  - A channel whose count is 0 loads the pending config on the cycle after acceptance.
  - A mid-block channel finishes its current block with its old config.
- Per-channel counter (0 .. 2^k−1) advances on each data_in_valid[c].
  - First batch of a block: accumulator per sample = sign-extended input (sum/average) or the input (peak).
  - Later batches: acc += x (sum/average) or acc = max(acc, x), signed (peak).
- Result on the 2^k-th batch, per sample:
  - Average: acc >>> k (arithmetic, floor). Always fits SAMPLE_WIDTH.
  - Sum: acc saturated to [MIN_SAMP, MAX_SAMP] = [−2^(SAMPLE_WIDTH−1), 2^(SAMPLE_WIDTH−1)−1].
  - Peak: acc.
- k = 0: every valid input batch is a complete block; the output equals the input in all modes.
- Output register, one per channel:
  - Loads the result and sets data_out_valid[c] if the register is empty, or if data_out_ready[c] is high in the same cycle (simultaneous consume and load, no overflow).
  - If the register holds an unconsumed result and ready is low, the new result is dropped, the old one is held, and overflow[c] is set.
  - data_out_valid[c] clears on a handshake with no new result.
- Channels are fully independent; the only shared state is the pending config.

## Timing
- Reset values:
  - data_out = 0, data_out_valid = 0, overflow = 0, cfg_ready = 0.
  - Counters = 0, accumulators = 0.
  - Active and pending config: k = 0, mode = average.
- Latency: data_out_valid[c] rises 1 cycle after the clk edge sampling the 2^k-th data_in_valid[c].
- Back-to-back valid inputs sustain full rate: at k = 0, one output per input cycle when ready is held high.
- Reset mid-block discards the partial accumulation and any held output. The first block after reset starts with the next valid input.
- data_out holds its value while data_out_valid is high and ready is low.

## Test plan
- Reset, k = 0, average; channel 0 inputs all 100 then all −3, ready = 1 → outputs all 100 then all −3, each 1 cycle after input; valid never set on other channels.
- k = 2, average; channel 2 batches with sample0 = 4, 5, 6, −20 → one output with sample0 = floor(−5/4) = −2 after the 4th input; no output after inputs 1–3.
- k = 3, sum; 8 batches of 0x7000 → output saturates to 0x7FFF. 8 batches of 0x9000 → output saturates to 0x8000.
- k = 1, peak; channel 5 inputs (−7, −2), then (3, 1) → outputs −2, then 3.
- k = 0, channel 1 ready held low for 3 valid inputs → first value held, overflow[1] = 1. Raising ready drains exactly one result. A cfg transaction then clears overflow.
- Cfg k = 2 → 1 accepted after 2 of 4 inputs on channel 0 → current block completes after 2 more inputs with k = 2; the next block emits after 2 inputs. cfg_log2_n = 15 with MAX_LOG2_N = 8 → blocks of 256.
